// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS MEM stage: LSU state encoding and
// the MEM/WB register layout with its bubble value.
package mips_pkg;

   localparam int WORD_W     = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } lsu_state_e;

   typedef struct packed {
      logic                  regwrite;
      logic                  memtoreg;
      logic [WORD_W-1:0]     read_data;
      logic [WORD_W-1:0]     result;
      logic [REG_ADDR_W-1:0] rd;
   } mem_wb_t;

   localparam int      MEM_WB_W      = $bits(mem_wb_t);
   localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register; bubble_i loads the all-zero bubble instead of d_i.
module mem_wb_pipe_reg
   import mips_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                bubble_i,
   input  logic [MEM_WB_W-1:0] d_i,
   output logic [MEM_WB_W-1:0] q_o
);

   logic [MEM_WB_W-1:0] wb_q;

   always_ff @(posedge clk) begin
      if (reset || bubble_i) wb_q <= MEM_WB_BUBBLE;
      else                   wb_q <= d_i;
   end

   assign q_o = wb_q;

endmodule

// File: rtl/mem_stage_lsu.sv
// MIPS MEM stage: branch resolve, word load/store over a req/ack bus with timeout.
// Optional MEM-stage forwarding is built when MEM_FWD_EN is defined.
module mem_stage_lsu
   import mips_pkg::*;
#(
   parameter int ACK_TIMEOUT = 64,
   parameter int TCNT_W      = 7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        branch_ex_mem,
   input  logic        memRead_ex_mem,
   input  logic        memWrite_ex_mem,
   input  logic        regwrite_ex_mem,
   input  logic        MemtoReg_ex_mem,
   input  logic [31:0] pc_branch_target_ex_mem,
   input  logic [31:0] result_ex_mem,
   input  logic [31:0] B_ex_mem,
   input  logic        zero_flag_ex_mem,
   input  logic [4:0]  Reg_dest_op_ex_mem,
   output logic        pcsrc,
   output logic [31:0] pc_branch_target_out,
   output logic        stall_mem,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        regwrite_mem_wb,
   output logic        MemtoReg_mem_wb,
   output logic [31:0] read_data_mem_wb,
   output logic [31:0] result_mem_wb,
   output logic [4:0]  Reg_dest_op_mem_wb,
   output logic        bus_err,
   output logic        misalign_err,
   output logic        fwd_valid,
   output logic [4:0]  fwd_rd,
   output logic [31:0] fwd_data
);

   lsu_state_e        state_q, state_d;
   logic [TCNT_W-1:0] tcnt_q, tcnt_d;
   logic              abort_q, abort_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              req_q, req_d, we_q, we_d;
   logic [31:0]       addr_q, addr_d, wdata_q, wdata_d;
   logic              bus_err_q, bus_err_d, misalign_q, misalign_d;
   logic              wb_bubble;
   mem_wb_t           wb_d, wb_q;
   logic              mem_op;

   assign mem_op               = memRead_ex_mem | memWrite_ex_mem;
   assign pcsrc                = branch_ex_mem & zero_flag_ex_mem;
   assign pc_branch_target_out = pc_branch_target_ex_mem;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         tcnt_q     <= '0;
         abort_q    <= 1'b0;
         rdata_q    <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         bus_err_q  <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tcnt_q     <= tcnt_d;
         abort_q    <= abort_d;
         rdata_q    <= rdata_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         bus_err_q  <= bus_err_d;
         misalign_q <= misalign_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      tcnt_d     = tcnt_q;
      abort_d    = abort_q;
      rdata_d    = rdata_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      bus_err_d  = 1'b0;
      misalign_d = 1'b0;
      stall_mem  = 1'b0;
      wb_bubble  = 1'b0;
      wb_d.regwrite  = regwrite_ex_mem;
      wb_d.memtoreg  = MemtoReg_ex_mem;
      wb_d.read_data = '0;
      wb_d.result    = result_ex_mem;
      wb_d.rd        = Reg_dest_op_ex_mem;
      case (state_q)
         IDLE: begin
            if (mem_op) begin
               wb_bubble = 1'b1;
               if (result_ex_mem[1:0] == 2'b00) begin
                  stall_mem = 1'b1;
                  req_d     = 1'b1;
                  we_d      = memWrite_ex_mem;
                  addr_d    = result_ex_mem;
                  wdata_d   = B_ex_mem;
                  tcnt_d    = '0;
                  abort_d   = 1'b0;
                  rdata_d   = '0;
                  state_d   = REQ;
               end else begin
                  misalign_d = 1'b1;
               end
            end
         end
         REQ: begin
            stall_mem = 1'b1;
            wb_bubble = 1'b1;
            if (dmem_ack) begin
               req_d   = 1'b0;
               rdata_d = dmem_rdata;
               state_d = DONE;
            end else if (tcnt_q == TCNT_W'(ACK_TIMEOUT - 1)) begin
               req_d     = 1'b0;
               bus_err_d = 1'b1;
               abort_d   = 1'b1;
               state_d   = DONE;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         DONE: begin
            // EX/MEM is still frozen on the access instruction here.
            wb_d.read_data = rdata_q;
            wb_d.regwrite  = regwrite_ex_mem & ~memWrite_ex_mem & ~abort_q;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   mem_wb_pipe_reg u_mem_wb (
      .clk      (clk),
      .reset    (reset),
      .bubble_i (wb_bubble),
      .d_i      (wb_d),
      .q_o      (wb_q)
   );

   assign regwrite_mem_wb    = wb_q.regwrite;
   assign MemtoReg_mem_wb    = wb_q.memtoreg;
   assign read_data_mem_wb   = wb_q.read_data;
   assign result_mem_wb      = wb_q.result;
   assign Reg_dest_op_mem_wb = wb_q.rd;
   assign dmem_req           = req_q;
   assign dmem_we            = we_q;
   assign dmem_addr          = addr_q;
   assign dmem_wdata         = wdata_q;
   assign bus_err            = bus_err_q;
   assign misalign_err       = misalign_q;

`ifdef MEM_FWD_EN
   assign fwd_valid = regwrite_ex_mem & ~MemtoReg_ex_mem & ~stall_mem;
   assign fwd_rd    = Reg_dest_op_ex_mem;
   assign fwd_data  = result_ex_mem;
`else
   assign fwd_valid = 1'b0;
   assign fwd_rd    = '0;
   assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: stimulus pushes expected write-back and
// error events into a queue; a monitor pops and compares as they appear.
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        reset;
   logic        branch_ex_mem, memRead_ex_mem, memWrite_ex_mem;
   logic        regwrite_ex_mem, MemtoReg_ex_mem;
   logic [31:0] pc_branch_target_ex_mem, result_ex_mem, B_ex_mem;
   logic        zero_flag_ex_mem;
   logic [4:0]  Reg_dest_op_ex_mem;
   logic        pcsrc;
   logic [31:0] pc_branch_target_out;
   logic        stall_mem, dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        dmem_ack;
   logic        regwrite_mem_wb, MemtoReg_mem_wb;
   logic [31:0] read_data_mem_wb, result_mem_wb;
   logic [4:0]  Reg_dest_op_mem_wb;
   logic        bus_err, misalign_err, fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;

   mem_stage_lsu dut (
      .clk(clk), .reset(reset),
      .branch_ex_mem(branch_ex_mem), .memRead_ex_mem(memRead_ex_mem),
      .memWrite_ex_mem(memWrite_ex_mem), .regwrite_ex_mem(regwrite_ex_mem),
      .MemtoReg_ex_mem(MemtoReg_ex_mem), .pc_branch_target_ex_mem(pc_branch_target_ex_mem),
      .result_ex_mem(result_ex_mem), .B_ex_mem(B_ex_mem), .zero_flag_ex_mem(zero_flag_ex_mem),
      .Reg_dest_op_ex_mem(Reg_dest_op_ex_mem), .pcsrc(pcsrc),
      .pc_branch_target_out(pc_branch_target_out), .stall_mem(stall_mem),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .regwrite_mem_wb(regwrite_mem_wb), .MemtoReg_mem_wb(MemtoReg_mem_wb),
      .read_data_mem_wb(read_data_mem_wb), .result_mem_wb(result_mem_wb),
      .Reg_dest_op_mem_wb(Reg_dest_op_mem_wb), .bus_err(bus_err), .misalign_err(misalign_err),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
   );

   always #5 clk = ~clk;

   localparam int K_WB = 0, K_BUS = 1, K_MIS = 2;
   typedef struct {
      int          kind;
      logic        rw;
      logic        mtr;
      logic [31:0] rdata;
      logic [31:0] res;
      logic [4:0]  rd;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   logic mon_en = 1'b0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endfunction

   function automatic void push(int kind, logic rw, logic mtr, logic [31:0] rdata,
                                logic [31:0] res, logic [4:0] rd);
      exp_t e;
      e.kind = kind; e.rw = rw; e.mtr = mtr; e.rdata = rdata; e.res = res; e.rd = rd;
      q.push_back(e);
   endfunction

   function automatic void pop_check(int kind);
      exp_t e;
      if (q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected_event actual=kind%0d required=none", kind);
         return;
      end
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == K_WB && e.kind == K_WB) begin
         chk("wb_regwrite", regwrite_mem_wb, e.rw);
         chk("wb_memtoreg", MemtoReg_mem_wb, e.mtr);
         chk("wb_read_data", read_data_mem_wb, e.rdata);
         chk("wb_result", result_mem_wb, e.res);
         chk("wb_rd", Reg_dest_op_mem_wb, e.rd);
      end
   endfunction

   // Monitor: any pulse or non-bubble MEM/WB content is an output event.
   initial begin
      wait (mon_en);
      forever begin
         @(negedge clk);
         if (bus_err === 1'b1) pop_check(K_BUS);
         if (misalign_err === 1'b1) pop_check(K_MIS);
         if ((regwrite_mem_wb | MemtoReg_mem_wb | (|read_data_mem_wb) |
              (|result_mem_wb) | (|Reg_dest_op_mem_wb)) === 1'b1)
            pop_check(K_WB);
      end
   end

   task automatic idle_inputs();
      branch_ex_mem = 0; memRead_ex_mem = 0; memWrite_ex_mem = 0;
      regwrite_ex_mem = 0; MemtoReg_ex_mem = 0; zero_flag_ex_mem = 0;
      pc_branch_target_ex_mem = '0; result_ex_mem = '0; B_ex_mem = '0;
      Reg_dest_op_ex_mem = '0;
   endtask

   task automatic check_regs_zero(string tag);
      chk({tag, "_dmem_req"}, dmem_req, 0);
      chk({tag, "_dmem_we"}, dmem_we, 0);
      chk({tag, "_dmem_addr"}, dmem_addr, 0);
      chk({tag, "_dmem_wdata"}, dmem_wdata, 0);
      chk({tag, "_wb_fields"}, {regwrite_mem_wb, MemtoReg_mem_wb, Reg_dest_op_mem_wb}, 0);
      chk({tag, "_wb_read_data"}, read_data_mem_wb, 0);
      chk({tag, "_wb_result"}, result_mem_wb, 0);
      chk({tag, "_errs"}, {bus_err, misalign_err}, 0);
   endtask

   // Called just after a rising edge; holds EX/MEM while stall_mem is high.
   task automatic run_op(input logic mr, input logic mw, input logic rw, input logic mtr,
                         input logic [31:0] res, input logic [31:0] b, input logic [4:0] rd,
                         input int ack_at, input logic [31:0] rdat,
                         output int stalls, output int reqs, output logic stable,
                         output logic we0, output logic [31:0] addr0, output logic [31:0] wd0);
      logic st;
      logic finished;
      memRead_ex_mem = mr; memWrite_ex_mem = mw; regwrite_ex_mem = rw; MemtoReg_ex_mem = mtr;
      result_ex_mem = res; B_ex_mem = b; Reg_dest_op_ex_mem = rd;
      stalls = 0; reqs = 0; stable = 1'b1; finished = 1'b0;
      we0 = 1'b0; addr0 = '0; wd0 = '0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (dmem_req) begin
            reqs++;
            if (reqs == 1) begin
               we0 = dmem_we; addr0 = dmem_addr; wd0 = dmem_wdata;
            end else if (dmem_we !== we0 || dmem_addr !== addr0 || dmem_wdata !== wd0) begin
               stable = 1'b0;
            end
            if (reqs == ack_at) begin
               dmem_ack = 1'b1; dmem_rdata = rdat;
            end
         end
         st = stall_mem;
         if (st) stalls++;
         @(posedge clk); #1;
         dmem_ack = 1'b0; dmem_rdata = '0;
         if (!st) begin
            finished = 1'b1;
            break;
         end
      end
      chk("op_completed", finished, 1'b1);
      idle_inputs();
   endtask

   int          stalls, reqs;
   logic        stable, we0;
   logic [31:0] addr0, wd0;

   initial begin
      idle_inputs();
      dmem_ack = 0; dmem_rdata = '0; reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_regs_zero("reset");
      chk("reset_stall", stall_mem, 0);
      chk("fwd_off", {fwd_valid, fwd_rd, fwd_data}, 0);
      reset = 1'b0;
      mon_en = 1'b1;
      @(posedge clk); #1;

      // ALU op passes through in one cycle
      push(K_WB, 1, 0, 32'h0, 32'h10, 5'd5);
      run_op(0, 0, 1, 0, 32'h10, 32'h0, 5'd5, 0, 0, stalls, reqs, stable, we0, addr0, wd0);
      chk("alu_stalls", stalls, 0);
      chk("alu_result_now", result_mem_wb, 32'h10);
      chk("alu_reqs", reqs, 0);
      @(posedge clk); #1;

      // branch resolved combinationally
      branch_ex_mem = 1; zero_flag_ex_mem = 1; pc_branch_target_ex_mem = 32'h200;
      #1;
      chk("pcsrc_taken", pcsrc, 1);
      chk("branch_target", pc_branch_target_out, 32'h200);
      chk("branch_stall", stall_mem, 0);
      zero_flag_ex_mem = 0;
      #1;
      chk("pcsrc_not_taken", pcsrc, 0);
      @(posedge clk); #1;
      idle_inputs();

      // load, ack in first REQ cycle
      push(K_WB, 1, 1, 32'hDEADBEEF, 32'h100, 5'd8);
      run_op(1, 0, 1, 1, 32'h100, 32'h0, 5'd8, 1, 32'hDEADBEEF, stalls, reqs, stable, we0, addr0, wd0);
      chk("load_stalls", stalls, 2);
      chk("load_reqs", reqs, 1);
      chk("load_addr", addr0, 32'h100);
      chk("load_we", we0, 0);
      chk("load_latency_data", read_data_mem_wb, 32'hDEADBEEF);
      @(posedge clk); #1;

      // store, ack on the fifth REQ cycle
      push(K_WB, 0, 0, 32'h0, 32'h40, 5'd9);
      run_op(0, 1, 1, 0, 32'h40, 32'h12345678, 5'd9, 5, 32'h0, stalls, reqs, stable, we0, addr0, wd0);
      chk("store_reqs", reqs, 5);
      chk("store_stalls", stalls, 6);
      chk("store_stable", stable, 1);
      chk("store_we", we0, 1);
      chk("store_addr", addr0, 32'h40);
      chk("store_wdata", wd0, 32'h12345678);
      @(posedge clk); #1;

      // load with no ack times out
      push(K_BUS, 0, 0, 0, 0, 0);
      push(K_WB, 0, 1, 32'h0, 32'h80, 5'd10);
      run_op(1, 0, 1, 1, 32'h80, 32'h0, 5'd10, 0, 0, stalls, reqs, stable, we0, addr0, wd0);
      chk("timeout_reqs", reqs, 64);
      chk("timeout_stalls", stalls, 65);
      chk("timeout_req_dropped", dmem_req, 0);
      @(posedge clk); #1;

      // misaligned load: no request, no stall
      push(K_MIS, 0, 0, 0, 0, 0);
      run_op(1, 0, 1, 1, 32'h102, 32'h0, 5'd11, 1, 32'h0, stalls, reqs, stable, we0, addr0, wd0);
      chk("misalign_stalls", stalls, 0);
      chk("misalign_reqs", reqs, 0);
      chk("misalign_req_now", dmem_req, 0);
      @(posedge clk); #1;

      // stray ack in IDLE, then another ALU op
      dmem_ack = 1; dmem_rdata = 32'hFFFF0000;
      @(posedge clk); #1;
      dmem_ack = 0; dmem_rdata = '0;
      chk("stray_ack_req", dmem_req, 0);
      push(K_WB, 1, 0, 32'h0, 32'hFFFFFFFC, 5'd31);
      run_op(0, 0, 1, 0, 32'hFFFFFFFC, 32'h0, 5'd31, 0, 0, stalls, reqs, stable, we0, addr0, wd0);
      chk("alu2_stalls", stalls, 0);
      @(posedge clk); #1;

      // reset in the middle of REQ
      memRead_ex_mem = 1; regwrite_ex_mem = 1; MemtoReg_ex_mem = 1;
      result_ex_mem = 32'h300; Reg_dest_op_ex_mem = 5'd12;
      repeat (3) @(negedge clk);
      chk("midreq_req_high", dmem_req, 1);
      reset = 1'b1;
      idle_inputs();
      @(posedge clk); #1;
      check_regs_zero("midreq_reset");
      chk("midreq_stall", stall_mem, 0);
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("after_reset_req", dmem_req, 0);
      chk("queue_empty", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
